// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state encoding and defaults for the memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_D  = 2'd2
    } arb_state_e;

    localparam int c_STARVE_MAX = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch/data) arbiter onto a single-cycle memory port.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N          = 100,
    parameter int STARVE_MAX = c_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int              c_CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CW-1:0] c_SMAX = c_CW'(STARVE_MAX);

    arb_state_e      r_state, w_state_nxt;
    logic [c_CW-1:0] r_starve_cnt, w_starve_nxt;
    logic            r_err, w_err_nxt;
    logic            r_wr, w_wr_nxt;

    logic [31:0] w_if_idx, w_d_idx;
    logic        w_if_inr, w_d_inr;
    logic        w_if_gnt, w_d_gnt;
    logic        w_unused_bits;

    assign w_unused_bits = ^{if_addr[1:0], d_addr[1:0]};

    assign w_if_idx = {2'b00, if_addr[31:2]};
    assign w_d_idx  = {2'b00, d_addr[31:2]};
    assign w_if_inr = (w_if_idx < 32'(N));
    assign w_d_inr  = (w_d_idx < 32'(N));

    // Data wins unless the fetch side has been passed over STARVE_MAX times.
    assign w_if_gnt = rst_n & if_req & (~d_req | (r_starve_cnt == c_SMAX));
    assign w_d_gnt  = rst_n & d_req & ~w_if_gnt;
    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (w_d_gnt && w_d_inr) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = w_d_idx;
            mem_wdata = d_wdata;
        end else if (w_if_gnt && w_if_inr) begin
            mem_en    = 1'b1;
            mem_addr  = w_if_idx;
        end
    end

    always_comb begin
        w_state_nxt  = IDLE;
        w_err_nxt    = 1'b0;
        w_wr_nxt     = 1'b0;
        w_starve_nxt = r_starve_cnt;
        if (w_if_gnt) begin
            w_state_nxt = RSP_IF;
            w_err_nxt   = ~w_if_inr;
        end else if (w_d_gnt) begin
            w_state_nxt = RSP_D;
            w_err_nxt   = ~w_d_inr;
            w_wr_nxt    = d_we;
        end

        if (w_if_gnt || !if_req) begin
            w_starve_nxt = '0;
        end else if (w_d_gnt && (r_starve_cnt != c_SMAX)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_err        <= 1'b0;
            r_wr         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_err        <= w_err_nxt;
            r_wr         <= w_wr_nxt;
        end
    end

    // Write acknowledges and range errors return zero data.
    assign if_rvalid = (r_state == RSP_IF);
    assign if_err    = if_rvalid & r_err;
    assign if_rdata  = (if_rvalid && !r_err) ? mem_rdata : 32'd0;
    assign d_rvalid  = (r_state == RSP_D);
    assign d_err     = d_rvalid & r_err;
    assign d_rdata   = (d_rvalid && !r_err && !r_wr) ? mem_rdata : 32'd0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.N(100), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
        mem[2] = 32'h0050_0093;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[6:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          side;
        logic [31:0] rd;
        logic        err;
        int          due;
    } rsp_t;
    rsp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: each negedge, a due response must appear on the right side only.
    always @(negedge clk) begin
        rsp_t e;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_rsp: got none required side %0d due %0d", e.side, e.due);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.side == 1'b0) begin
                chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
                chk("d_rvalid_quiet", {31'd0, d_rvalid}, 32'd0);
                chk("if_rdata", if_rdata, e.rd);
                chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            end else begin
                chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
                chk("if_rvalid_quiet", {31'd0, if_rvalid}, 32'd0);
                chk("d_rdata", d_rdata, e.rd);
                chk("d_err", {31'd0, d_err}, {31'd0, e.err});
            end
        end else begin
            chk("no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            chk("idle_data_zero", if_rdata | d_rdata | {31'd0, if_err | d_err}, 32'd0);
        end
    end

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic eig, input logic edg, input logic een, input logic [31:0] ema,
                        input logic [31:0] erd, input logic eerr, input string nm);
        rsp_t e;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
        chk({nm, ".if_gnt"}, {31'd0, if_gnt}, {31'd0, eig});
        chk({nm, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, edg});
        chk({nm, ".mem_en"}, {31'd0, mem_en}, {31'd0, een});
        chk({nm, ".mem_we"}, {31'd0, mem_we}, {31'd0, een & edg & dw});
        if (een) chk({nm, ".mem_addr"}, mem_addr, ema);
        if (een && edg && dw) chk({nm, ".mem_wdata"}, mem_wdata, dwd);
        if (eig || edg) begin
            e.side = edg; e.rd = erd; e.err = eerr; e.due = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst.d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst.mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(1, 32'h8,   0, 0, 32'h0,    32'h0,        1, 0, 1, 32'd2, 32'h0050_0093, 0, "fetch");
        step(0, 32'h0,   1, 1, 32'h10,   32'hDEADBEEF, 0, 1, 1, 32'd4, 32'h0, 0, "write");
        step(0, 32'h0,   1, 0, 32'h13,   32'h0,        0, 1, 1, 32'd4, 32'hDEADBEEF, 0, "readback");
        step(1, 32'h190, 0, 0, 32'h0,    32'h0,        1, 0, 0, 32'd0, 32'h0, 1, "if_oob");
        step(0, 32'h0,   1, 0, 32'h1000, 32'h0,        0, 1, 0, 32'd0, 32'h0, 1, "d_oob_rd");
        step(0, 32'h0,   1, 1, 32'h400,  32'h1234,     0, 1, 0, 32'd0, 32'h0, 1, "d_oob_wr");
        step(0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 0, 0, 32'd0, 32'h0, 0, "idle");

        for (int i = 0; i < 4; i++)
            step(1, 32'h8, 1, 0, 32'h14, 32'h0, 0, 1, 1, 32'd5, 32'hA500_0005, 0, "starve_d");
        step(1, 32'h8, 1, 0, 32'h14, 32'h0, 1, 0, 1, 32'd2, 32'h0050_0093, 0, "starve_if");
        step(1, 32'h8, 1, 0, 32'h14, 32'h0, 0, 1, 1, 32'd5, 32'hA500_0005, 0, "starve_resume");

        step(1, 32'hC, 0, 0, 32'h0,  32'h0,        1, 0, 1, 32'd3, 32'hA500_0003, 0, "alt_if0");
        step(0, 32'h0, 1, 0, 32'h14, 32'h0,        0, 1, 1, 32'd5, 32'hA500_0005, 0, "alt_d0");
        step(1, 32'h8, 0, 0, 32'h0,  32'h0,        1, 0, 1, 32'd2, 32'h0050_0093, 0, "alt_if1");
        step(0, 32'h0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 1, 1, 32'd8, 32'h0, 0, "alt_dw");
        step(1, 32'hC, 1, 0, 32'h20, 32'h0,        0, 1, 1, 32'd8, 32'hCAFEF00D, 0, "alt_dr");
        step(0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'd0, 32'h0, 0, "idle2");

        // Build up starvation, then reset with a data response still owed.
        step(1, 32'h8, 1, 0, 32'h18, 32'h0, 0, 1, 1, 32'd6, 32'hA500_0006, 0, "pre_rst0");
        step(1, 32'h8, 1, 0, 32'h18, 32'h0, 0, 1, 1, 32'd6, 32'hA500_0006, 0, "pre_rst1");
        #1;
        chk("pre_rst2.d_gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rst_drop.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            step(1, 32'h8, 1, 0, 32'h18, 32'h0, 0, 1, 1, 32'd6, 32'hA500_0006, 0, "post_rst_d");
        step(1, 32'h8, 1, 0, 32'h18, 32'h0, 1, 0, 1, 32'd2, 32'h0050_0093, 0, "post_rst_if");
        step(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'd0, 32'h0, 0, "drain");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
